// File: rtl/posit_32_3_encoder.sv
// posit(32,3) encoder: packs sign/regime/exponent/fraction fields into a posit word.
// Three register stages: regime build, truncate + round-to-nearest-even, sign and specials.
module posit_32_3_encoder #(
    parameter int N  = 32,
    parameter int ES = 3,
    parameter int RS = 6,
    parameter int FS = N - 3 - ES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sign,
    input  logic signed [RS-1:0] regi,
    input  logic [ES-1:0]        expo,
    input  logic [FS-1:0]        frac,
    input  logic                 allzero,
    input  logic                 inf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out
);

    localparam int SW  = 2 * N - 2;        // 62-bit left-aligned regime/expo/frac string
    localparam int WW  = 64;                // seed width before dropping the 2 spare LSBs
    localparam int PAD = WW - 2 - ES - FS;
    localparam logic [N-2:0] MAXPOS = '1;
    localparam logic [N-2:0] MINPOS = {{(N-2){1'b0}}, 1'b1};

    // Handshake: a word moves on both ports only when valid and ready are high at the
    // same rising edge; the whole pipeline advances together on en, so a stalled output
    // holds out/out_valid and freezes every stage behind it.
    logic en;
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    // ---------------- stage 1: regime build ----------------
    logic          v1_q;
    logic [SW-1:0] str1_q, str1_d;
    logic          sat1_q, sat1_d;
    logic          satlo1_q, satlo1_d;
    logic          sign1_q, inf1_q, zero1_q;

    logic [WW-1:0] seed_hi, seed_lo, shifted;
    logic [4:0]    sh_amt;
    logic          sat_hi, sat_lo;

    assign seed_hi = {2'b10, expo, frac, {PAD{1'b0}}};
    assign seed_lo = {2'b01, expo, frac, {PAD{1'b0}}};
    assign sat_hi  = regi > 6'sd30;
    assign sat_lo  = regi < -6'sd30;

    always_comb begin
        sh_amt   = '0;
        shifted  = '0;
        sat1_d   = sat_hi | sat_lo;
        satlo1_d = sat_lo;
        if (regi >= 6'sd0) begin
            // arithmetic shift of 1,0,... by k yields k+1 ones followed by the terminator
            sh_amt  = regi[4:0];
            shifted = $signed(seed_hi) >>> sh_amt;
        end else begin
            // ~k == -k-1 : logical shift of 0,1,... gives -k zeros then the terminator
            sh_amt  = ~regi[4:0];
            shifted = seed_lo >> sh_amt;
        end
        str1_d = shifted[WW-1:WW-SW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            str1_q   <= '0;
            sat1_q   <= 1'b0;
            satlo1_q <= 1'b0;
            sign1_q  <= 1'b0;
            inf1_q   <= 1'b0;
            zero1_q  <= 1'b0;
        end else if (en) begin
            v1_q     <= in_valid;
            str1_q   <= str1_d;
            sat1_q   <= sat1_d;
            satlo1_q <= satlo1_d;
            sign1_q  <= sign;
            inf1_q   <= inf;
            zero1_q  <= allzero;
        end
    end

    // ---------------- stage 2: truncate and round ----------------
    logic          v2_q;
    logic [N-2:0]  mag2_q, mag2_d;
    logic          sign2_q, inf2_q, zero2_q;

    logic [N-2:0]  trunc;
    logic          guard, sticky, rnd_up;
    logic [N-1:0]  sum;

    assign trunc  = str1_q[SW-1:SW-(N-1)];
    assign guard  = str1_q[SW-N];
    assign sticky = |str1_q[SW-N-1:0];
    assign rnd_up = guard & (trunc[0] | sticky);
    assign sum    = {1'b0, trunc} + {{(N-1){1'b0}}, rnd_up};

    always_comb begin
        mag2_d = sum[N-2:0];
        if (sum[N-1])
            mag2_d = MAXPOS;
        if (sat1_q)
            mag2_d = satlo1_q ? MINPOS : MAXPOS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            mag2_q  <= '0;
            sign2_q <= 1'b0;
            inf2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else if (en) begin
            v2_q    <= v1_q;
            mag2_q  <= mag2_d;
            sign2_q <= sign1_q;
            inf2_q  <= inf1_q;
            zero2_q <= zero1_q;
        end
    end

    // ---------------- stage 3: sign and specials ----------------
    logic          out_valid_q;
    logic [N-1:0]  out_q, out_d;
    logic [N-1:0]  word;

    assign word = {1'b0, mag2_q};

    always_comb begin
        out_d = sign2_q ? (~word + 1'b1) : word;
        if (inf2_q)
            out_d = {1'b1, {(N-1){1'b0}}};
        else if (zero2_q)
            out_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (en) begin
            out_valid_q <= v2_q;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_posit_32_3_encoder.sv
// Self-checking bench for posit_32_3_encoder: directed vectors, a reference decoder for
// round-trip words, backpressure and mid-stream reset, all scored through an expected queue.
module tb_posit_32_3_encoder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               sign = 1'b0;
    logic signed [5:0]  regi = '0;
    logic [2:0]         expo = '0;
    logic [25:0]        frac = '0;
    logic               allzero = 1'b0;
    logic               inf = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out;

    int                 compared = 0;
    int                 mismatched = 0;
    int                 rdy_mode = 1;        // 0: stall, 1: always ready, 2: random
    logic [31:0]        exp_q[$];

    posit_32_3_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .regi      (regi),
        .expo      (expo),
        .frac      (frac),
        .allzero   (allzero),
        .inf       (inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    // ---------------- clock / reset / ready ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard_extra: got out=%08h, required no output", out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out !== e) begin
                    mismatched++;
                    $display("FAIL scoreboard_word: got out=%08h, required %08h", out, e);
                end
            end
        end
    end

    // ---------------- reference decoder ----------------
    task automatic decode(input logic [31:0] w, output logic s, output logic signed [5:0] k,
                          output logic [2:0] e, output logic [25:0] f);
        logic [31:0] a;
        logic [30:0] body;
        logic [63:0] t;
        logic        r;
        logic        run;
        int          c;
        s    = w[31];
        a    = s ? -w : w;
        body = a[30:0];
        r    = body[30];
        c    = 0;
        run  = 1'b1;
        for (int i = 30; i >= 0; i--) begin
            if (run && body[i] == r) c++;
            else run = 1'b0;
        end
        k = r ? 6'(c - 1) : 6'(-c);
        t = {body, 33'b0} << (c + 1);
        {e, f} = t[63:35];
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        while (w == 32'h0 || w == 32'h8000_0000) w = $urandom;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic s, input logic signed [5:0] k, input logic [2:0] e,
                        input logic [25:0] f, input logic z, input logic i,
                        input logic [31:0] exp_w);
        logic accepted;
        accepted = 1'b0;
        sign = s; regi = k; expo = e; frac = f; allzero = z; inf = i;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp_w);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: in_ready stayed 0, required an accept");
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic s; logic signed [5:0] k; logic [2:0] e; logic [25:0] f;
        decode(w, s, k, e, f);
        send(s, k, e, f, 1'b0, 1'b0, w);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic measure_latency(input string name);
        int cnt;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        compared++;
        if (cnt != 3) begin
            mismatched++;
            $display("FAIL %s: got %0d cycles, required 3", name, cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: got out_valid=%b out=%08h, required 0/00000000", out_valid, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release: got out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        send(1'b0, 6'sd0,  3'd0, 26'd0, 1'b0, 1'b0, 32'h4000_0000);
        send(1'b1, 6'sd0,  3'd0, 26'd0, 1'b0, 1'b0, 32'hC000_0000);
        send(1'b0, -6'sd1, 3'd0, 26'd0, 1'b0, 1'b0, 32'h2000_0000);
        send(1'b0, 6'sd1,  3'd0, 26'd0, 1'b0, 1'b0, 32'h6000_0000);
        send(1'b0, 6'sd0,  3'd0, 26'd0, 1'b0, 1'b1, 32'h8000_0000);
        send(1'b0, 6'sd0,  3'd0, 26'd0, 1'b1, 1'b0, 32'h0000_0000);
        send(1'b0, 6'sd0,  3'd0, 26'd0, 1'b1, 1'b1, 32'h8000_0000);
        send(1'b1, 6'sd5,  3'd6, 26'h3ABCDEF, 1'b1, 1'b0, 32'h0000_0000);
        drain();
    endtask

    task automatic test_rounding();
        send(1'b0, 6'sd27, 3'b011, 26'd0, 1'b0, 1'b0, 32'h7FFF_FFFA);
        send(1'b0, 6'sd27, 3'b001, 26'd0, 1'b0, 1'b0, 32'h7FFF_FFF8);
        send(1'b0, 6'sd27, 3'b001, 26'd1, 1'b0, 1'b0, 32'h7FFF_FFF9);
        send(1'b0, 6'sd29, 3'b111, 26'd0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        drain();
    endtask

    task automatic test_saturation();
        send(1'b0, 6'sd31,  3'd0, 26'd0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        send(1'b0, 6'sd30,  3'd7, 26'd0, 1'b0, 1'b0, 32'h7FFF_FFFF);
        send(1'b0, -6'sd32, 3'd0, 26'd0, 1'b0, 1'b0, 32'h0000_0001);
        send(1'b0, -6'sd30, 3'd0, 26'd0, 1'b0, 1'b0, 32'h0000_0001);
        send(1'b0, -6'sd31, 3'd5, 26'd9, 1'b0, 1'b0, 32'h0000_0001);
        send(1'b1, 6'sd31,  3'd0, 26'd0, 1'b0, 1'b0, 32'h8000_0001);
        send(1'b1, -6'sd32, 3'd0, 26'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        drain();
    endtask

    task automatic test_round_trip();
        send_word(rand_word());
        measure_latency("round_trip_latency");
        rdy_mode = 2;
        for (int i = 1; i < 10000; i++) send_word(rand_word());
        rdy_mode = 1;
        drain();
    endtask

    task automatic test_backpressure();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) send_word(rand_word());
            end
            begin
                logic [31:0] held;
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                compared++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_ready: got out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
                end
                held = out;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    compared++;
                    if (out !== held || out_valid !== 1'b1) begin
                        mismatched++;
                        $display("FAIL stall_hold: got out=%08h valid=%b, required %08h/1", out, out_valid, held);
                    end
                end
                rdy_mode = 1;
            end
        join
        drain();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL stall_loss: %0d words missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) send_word(rand_word());
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || out !== 32'h0) begin
            mismatched++;
            $display("FAIL async_reset: got out_valid=%b out=%08h, required 0/00000000", out_valid, out);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL stale_word: got out_valid=1 out=%08h, required out_valid=0", out);
            end
        end
        @(posedge clk);
        #1;
        send_word(rand_word());
        measure_latency("post_reset_latency");
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_round_trip();
        test_backpressure();
        test_reset_midstream();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL final_queue: %0d words outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
